// File: rtl/reg_arb_pkg.sv
// Shared types and constants for the register-port arbiter.
// REG_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
package reg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DONE
    } state_t;

    localparam int DATA_W_DEF = 32;
    localparam int MAX_REQ    = 8;
    localparam int IDX_W      = $clog2(MAX_REQ);

    function automatic int be_w(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/reg_arb_picker.sv
// Combinational winner search over the request vector.
// REG_ARB_FIXED_PRIO_EN: lowest index wins and rr_ptr is ignored.
module reg_arb_picker
    import reg_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [IDX_W-1:0]   grant,
    output logic               any_valid
);

    logic             hit_lo;
    logic [IDX_W-1:0] idx_lo;

`ifndef REG_ARB_FIXED_PRIO_EN
    logic             hit_hi;
    logic [IDX_W-1:0] idx_hi;

    // Two passes: first at/above the pointer, then wrap to the bottom.
    always_comb begin
        hit_hi = 1'b0;
        idx_hi = '0;
        hit_lo = 1'b0;
        idx_lo = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!hit_hi && req_valid[j] && (IDX_W'(j) >= rr_ptr)) begin
                hit_hi = 1'b1;
                idx_hi = IDX_W'(j);
            end
            if (!hit_lo && req_valid[j]) begin
                hit_lo = 1'b1;
                idx_lo = IDX_W'(j);
            end
        end
    end

    assign grant = hit_hi ? idx_hi : idx_lo;
`else
    logic unused_ptr;
    assign unused_ptr = ^rr_ptr;

    always_comb begin
        hit_lo = 1'b0;
        idx_lo = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!hit_lo && req_valid[j]) begin
                hit_lo = 1'b1;
                idx_lo = IDX_W'(j);
            end
        end
    end

    assign grant = idx_lo;
`endif

    assign any_valid = |req_valid;

endmodule

// File: rtl/reg_avalon_arbiter.sv
// Shares one Avalon-MM register slave among NUM_REQ requesters.
// REG_ARB_FIXED_PRIO_EN selects fixed priority (no rr_ptr).
module reg_avalon_arbiter
    import reg_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int DATA_W  = DATA_W_DEF,
    localparam int BE_W    = be_w(DATA_W)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*BE_W-1:0]   req_byteenable,
    input  logic [NUM_REQ*DATA_W-1:0] req_writedata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_readdata,
    output logic                      av_chipselect,
    output logic                      av_read,
    output logic                      av_write,
    output logic [BE_W-1:0]           av_byteenable,
    output logic [DATA_W-1:0]         av_writedata,
    input  logic [DATA_W-1:0]         av_readdata,
    input  logic                      av_waitrequest
);

    state_t           state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] grant;
    logic [IDX_W-1:0] g_q;
    logic             any_valid;

    logic               sel_write;
    logic [BE_W-1:0]    sel_be;
    logic [DATA_W-1:0]  sel_wd;
    logic [NUM_REQ-1:0] grant_oh;
    logic [NUM_REQ-1:0] g_q_oh;

    reg_arb_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .any_valid (any_valid)
    );

    // Payload mux for the winner and one-hot decodes of both indices.
    always_comb begin
        sel_write = 1'b0;
        sel_be    = '0;
        sel_wd    = '0;
        grant_oh  = '0;
        g_q_oh    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant == IDX_W'(i)) begin
                sel_write   = req_write[i];
                sel_be      = req_byteenable[i*BE_W +: BE_W];
                sel_wd      = req_writedata[i*DATA_W +: DATA_W];
                grant_oh[i] = 1'b1;
            end
            if (g_q == IDX_W'(i)) begin
                g_q_oh[i] = 1'b1;
            end
        end
    end

    // The av_* registers double as the latched command.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            g_q           <= '0;
            req_ready     <= '0;
            rsp_valid     <= '0;
            rsp_readdata  <= '0;
            av_chipselect <= 1'b0;
            av_read       <= 1'b0;
            av_write      <= 1'b0;
            av_byteenable <= '0;
            av_writedata  <= '0;
        end else begin
            req_ready <= '0;
            rsp_valid <= '0;
            unique case (state)
                IDLE: begin
                    if (any_valid) begin
                        g_q           <= grant;
                        req_ready     <= grant_oh;
                        av_chipselect <= 1'b1;
                        av_write      <= sel_write;
                        av_read       <= ~sel_write;
                        av_byteenable <= sel_be;
                        av_writedata  <= sel_wd;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!av_waitrequest) begin
                        if (av_read) begin
                            rsp_readdata <= av_readdata;
                        end
                        rsp_valid     <= g_q_oh;
                        av_chipselect <= 1'b0;
                        av_read       <= 1'b0;
                        av_write      <= 1'b0;
                        av_byteenable <= '0;
                        av_writedata  <= '0;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifndef REG_ARB_FIXED_PRIO_EN
    logic [IDX_W-1:0] ptr_next;

    assign ptr_next = (g_q == IDX_W'(NUM_REQ - 1)) ?
                      '0 : g_q + IDX_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (state == DONE) begin
            rr_ptr <= ptr_next;
        end
    end
`else
    assign rr_ptr = '0;
`endif

endmodule

// File: tb/tb_reg_avalon_arbiter.sv
// Directed bench for reg_avalon_arbiter with a per-cycle reference model.
// Honors REG_ARB_FIXED_PRIO_EN for the starvation scenario.
module tb_reg_avalon_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int BW = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_write;
    logic [N*BW-1:0] req_byteenable;
    logic [N*DW-1:0] req_writedata;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_readdata;
    logic            av_chipselect;
    logic            av_read;
    logic            av_write;
    logic [BW-1:0]   av_byteenable;
    logic [DW-1:0]   av_writedata;
    logic [DW-1:0]   av_readdata;
    logic            av_waitrequest;

    reg_avalon_arbiter #(.NUM_REQ(N), .DATA_W(DW)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_write      (req_write),
        .req_byteenable (req_byteenable),
        .req_writedata  (req_writedata),
        .req_ready      (req_ready),
        .rsp_valid      (rsp_valid),
        .rsp_readdata   (rsp_readdata),
        .av_chipselect  (av_chipselect),
        .av_read        (av_read),
        .av_write       (av_write),
        .av_byteenable  (av_byteenable),
        .av_writedata   (av_writedata),
        .av_readdata    (av_readdata),
        .av_waitrequest (av_waitrequest)
    );

    int checks = 0;
    int failures = 0;

    // Reference expectations for the outputs after the next edge.
    logic [N-1:0]  e_ready, e_rsp;
    logic          e_cs, e_rd, e_wr;
    logic [BW-1:0] e_be;
    logic [DW-1:0] e_wd, e_rdata;
    int            own, ptr;

    // Requester/slave stimulus state.
    int            remaining [N];
    logic          wr_a [N];
    logic [BW-1:0] be_a [N];
    logic [DW-1:0] wd_a [N];
    int            wait_left;
    logic [N-1:0]  rdy_seen;
    int            gq [$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic int pick();
        int start;
`ifdef REG_ARB_FIXED_PRIO_EN
        start = 0;
`else
        start = ptr;
`endif
        for (int k = 0; k < N; k++) begin
            if (req_valid[(start + k) % N]) return (start + k) % N;
        end
        return 0;
    endfunction

    task automatic model_reset();
        e_ready = '0; e_rsp = '0;
        e_cs = 0; e_rd = 0; e_wr = 0;
        e_be = '0; e_wd = '0; e_rdata = '0;
        own = 0; ptr = 0;
    endtask

    // Predict the outputs after the next edge from the current ones.
    task automatic model_update();
        if (e_cs) begin
            e_ready = '0;
            if (!av_waitrequest) begin
                e_rsp = '0;
                e_rsp[own] = 1'b1;
                if (e_rd) e_rdata = av_readdata;
                e_cs = 0; e_rd = 0; e_wr = 0;
                e_be = '0; e_wd = '0;
            end
        end else if (e_rsp != '0) begin
            e_rsp = '0;
            ptr = (own + 1) % N;
        end else if (req_valid != '0) begin
            own = pick();
            e_ready = '0;
            e_ready[own] = 1'b1;
            e_cs = 1;
            e_wr = req_write[own];
            e_rd = !req_write[own];
            e_be = req_byteenable[own*BW +: BW];
            e_wd = req_writedata[own*DW +: DW];
        end
    endtask

    task automatic compare();
        checks++;
        if (req_ready !== e_ready || rsp_valid !== e_rsp ||
            av_chipselect !== e_cs || av_read !== e_rd ||
            av_write !== e_wr || av_byteenable !== e_be ||
            av_writedata !== e_wd || rsp_readdata !== e_rdata) begin
            failures++;
            $display({"FAIL cycle_cmp t=%0t (actual/required) ready=%b/%b",
                      " rsp=%b/%b cs=%b/%b rd=%b/%b wr=%b/%b be=%h/%h",
                      " wd=%h/%h rdata=%h/%h"},
                     $time, req_ready, e_ready, rsp_valid, e_rsp,
                     av_chipselect, e_cs, av_read, e_rd, av_write, e_wr,
                     av_byteenable, e_be, av_writedata, e_wd,
                     rsp_readdata, e_rdata);
        end
    endtask

    task automatic sample();
        if (reset) model_reset();
        compare();
        for (int i = 0; i < N; i++) begin
            if (req_ready[i]) gq.push_back(i);
        end
        rdy_seen = req_ready;
        if (!reset) model_update();
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (rdy_seen[i] && remaining[i] > 0) remaining[i]--;
            req_valid[i] = remaining[i] > 0;
            req_write[i] = wr_a[i];
            req_byteenable[i*BW +: BW] = be_a[i];
            req_writedata[i*DW +: DW] = wd_a[i];
        end
        rdy_seen = '0;
        av_waitrequest = av_chipselect && (wait_left > 0);
        if (av_waitrequest) wait_left--;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive();
        @(negedge clk);
        sample();
    endtask

    task automatic wait_ready(input string nm);
        int c;
        for (c = 0; c < 40; c++) begin
            step();
            if (req_ready != '0) break;
        end
        if (c == 40) chk({nm, "_ready_timeout"}, 32'(c), 32'd0);
    endtask

    task automatic settle();
        for (int c = 0; c < 60; c++) begin
            step();
            if (!av_chipselect && rsp_valid == '0 && req_valid == '0) break;
        end
        step();
    endtask

    task automatic run_grants(input int n, input int bound);
        gq.delete();
        for (int c = 0; c < bound && gq.size() < n; c++) step();
        chk("grant_count", 32'(gq.size()), 32'(n));
    endtask

    function automatic int gq_at(input int i);
        return (i < gq.size()) ? gq[i] : -1;
    endfunction

    task automatic clear_stim();
        for (int i = 0; i < N; i++) remaining[i] = 0;
        wait_left = 0;
        rdy_seen = '0;
        req_valid = '0;
        av_waitrequest = 1'b0;
    endtask

    task automatic pulse_reset();
        #2 reset = 1'b1;
        clear_stim();
        @(negedge clk);
        sample();
        #2 reset = 1'b0;
    endtask

    int cnt, csn, n0, n3;
    int ord3 [6];

    initial begin
        req_write = '0;
        req_byteenable = '0;
        req_writedata = '0;
        av_readdata = '0;
        for (int i = 0; i < N; i++) begin
            wr_a[i] = 1'b0;
            be_a[i] = 4'hF;
            wd_a[i] = 32'h1000_0000 + 32'(i);
        end
        clear_stim();
        model_reset();
        repeat (2) begin
            @(negedge clk);
            sample();
        end
        #2 reset = 1'b0;

        // Write from requester 0, zero wait
        wr_a[0] = 1'b1; be_a[0] = 4'hF; wd_a[0] = 32'hDEAD_BEEF;
        remaining[0] = 1;
        wait_ready("t1");
        chk("t1_ready", 32'(req_ready), 32'h1);
        chk("t1_av_write", 32'(av_write), 32'h1);
        chk("t1_av_cs", 32'(av_chipselect), 32'h1);
        chk("t1_av_wd", av_writedata, 32'hDEAD_BEEF);
        step();
        chk("t1_rsp", 32'(rsp_valid), 32'h1);
        settle();

        // Read from requester 2
        wr_a[2] = 1'b0; be_a[2] = 4'h3; av_readdata = 32'h1234_5678;
        remaining[2] = 1;
        wait_ready("t2");
        chk("t2_ready", 32'(req_ready), 32'h4);
        chk("t2_av_read", 32'(av_read), 32'h1);
        step();
        chk("t2_rsp", 32'(rsp_valid), 32'h4);
        chk("t2_rdata", rsp_readdata, 32'h1234_5678);
        settle();

        // All four from reset, then 0 and 1 again
        pulse_reset();
        av_readdata = 32'hCAFE_0003;
        wr_a[0] = 1'b1; wr_a[1] = 1'b0; wr_a[2] = 1'b1; wr_a[3] = 1'b0;
        for (int i = 0; i < N; i++) remaining[i] = 1;
        run_grants(4, 80);
        for (int i = 0; i < 4; i++) chk("t3_order", 32'(gq_at(i)), 32'(i));
        settle();
        remaining[0] = 1; remaining[1] = 1;
        run_grants(2, 40);
        chk("t3b_order0", 32'(gq_at(0)), 32'd0);
        chk("t3b_order1", 32'(gq_at(1)), 32'd1);
        settle();

        // Read with three waitrequest cycles
        wr_a[1] = 1'b0; av_readdata = 32'h0BAD_F00D;
        wait_left = 3;
        remaining[1] = 1;
        wait_ready("t4");
        chk("t4_ready", 32'(req_ready), 32'h2);
        cnt = 0; csn = 1;
        for (int c = 0; c < 20; c++) begin
            step();
            cnt++;
            if (rsp_valid != '0) break;
            if (av_chipselect) csn++;
        end
        chk("t4_rsp_cycle", 32'(cnt), 32'd4);
        chk("t4_cs_cycles", 32'(csn), 32'd4);
        chk("t4_rsp", 32'(rsp_valid), 32'h2);
        chk("t4_rdata", rsp_readdata, 32'h0BAD_F00D);
        settle();

        // Reset during ISSUE aborts the transaction
        wr_a[2] = 1'b0;
        wait_left = 100;
        remaining[2] = 1;
        wait_ready("t5");
        chk("t5_cs_before", 32'(av_chipselect), 32'h1);
        #2 reset = 1'b1;
        #1;
        chk("t5_cs_async", 32'(av_chipselect), 32'h0);
        chk("t5_rd_async", 32'(av_read), 32'h0);
        clear_stim();
        @(negedge clk);
        sample();
        #2 reset = 1'b0;
        wr_a[1] = 1'b1; wr_a[3] = 1'b1;
        remaining[1] = 1; remaining[3] = 1;
        run_grants(2, 40);
        chk("t5_first", 32'(gq_at(0)), 32'd1);
        chk("t5_second", 32'(gq_at(1)), 32'd3);
        settle();

`ifdef REG_ARB_FIXED_PRIO_EN
        // Requester 0 reissuing starves requester 3
        remaining[0] = 20; remaining[3] = 1;
        run_grants(20, 200);
        n0 = 0; n3 = 0;
        foreach (gq[i]) begin
            if (gq[i] == 0) n0++;
            if (gq[i] == 3) n3++;
        end
        chk("t6_req0_grants", 32'(n0), 32'd20);
        chk("t6_req3_grants", 32'(n3), 32'd0);
        settle();
`else
        // Requesters 0 and 3 both reissuing alternate
        ord3 = '{0, 3, 0, 3, 0, 3};
        remaining[0] = 3; remaining[3] = 3;
        run_grants(6, 80);
        for (int i = 0; i < 6; i++) chk("t6_order", 32'(gq_at(i)), 32'(ord3[i]));
        settle();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
